// File: rtl/riscv_pkg.sv
// Shared RV64 definitions for the writeback stage: opcodes, load widths,
// trap causes and trap-sequencer states.
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_OP32     = 7'b0111011;
  localparam logic [6:0] OP_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAVE   = 2'd1,
    VECTOR = 2'd2
  } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_load_ext.sv
// Sign/zero extension of low-aligned raw load data according to load funct3.
`default_nettype none

module wb_load_ext
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_raw,
  output logic [XLEN-1:0] o_data
);

  always_comb begin
    o_data = i_raw;
    case (i_funct3)
      F3_LB:  o_data = {{(XLEN-8){i_raw[7]}},   i_raw[7:0]};
      F3_LH:  o_data = {{(XLEN-16){i_raw[15]}}, i_raw[15:0]};
      F3_LW:  o_data = {{(XLEN-32){i_raw[31]}}, i_raw[31:0]};
      F3_LD:  o_data = i_raw;
      F3_LBU: o_data = {{(XLEN-8){1'b0}},  i_raw[7:0]};
      F3_LHU: o_data = {{(XLEN-16){1'b0}}, i_raw[15:0]};
      F3_LWU: o_data = {{(XLEN-32){1'b0}}, i_raw[31:0]};
      default: o_data = i_raw;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// Writeback stage: result select, register-file write, branch redirect,
// retired-instruction count and the IDLE->SAVE->VECTOR trap sequencer.
`default_nettype none

module writeback_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] MTVEC_ADDR = 64'h0000_0000_0000_0100
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            WB_V,
  input  logic [31:0]     WB_IR,
  input  logic [XLEN-1:0] WB_NPC,
  input  logic [XLEN-1:0] WB_ALU_RESULT,
  input  logic [XLEN-1:0] WB_MEM_RESULT,
  input  logic [XLEN-1:0] WB_CSRFD,
  input  logic            WB_PC_MUX,
  input  logic            WB_ECALL,
  input  logic            MEM_LAM,
  input  logic            MEM_SAM,
  output logic            WB_STALL,
  output logic            FLUSH,
  output logic            RF_WE,
  output logic [4:0]      RF_DR,
  output logic [XLEN-1:0] RF_DATA,
  output logic            PC_REDIRECT,
  output logic [XLEN-1:0] PC_TARGET,
  output logic            TRAP_V,
  output logic [XLEN-1:0] MEPC,
  output logic [XLEN-1:0] MCAUSE,
  output logic [63:0]     INSTRET
);

  wb_state_t       r_state, w_state_next;
  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [2:0]      w_funct3;
  logic            w_consume, w_trap, w_writes, w_retire;
  logic [3:0]      w_cause;
  logic [XLEN-1:0] w_wdata, w_ld_data;
  logic            w_unused_ir;

  logic            r_rf_we, r_redirect, r_br_flush, r_trap_v;
  logic [4:0]      r_rf_dr;
  logic [XLEN-1:0] r_rf_data, r_target, r_mepc, r_mcause;
  logic [63:0]     r_instret;

  assign w_opcode    = WB_IR[6:0];
  assign w_rd        = WB_IR[11:7];
  assign w_funct3    = WB_IR[14:12];
  assign w_unused_ir = ^WB_IR[31:15];
  assign w_consume   = WB_V && (r_state == IDLE);
  assign w_retire    = w_consume && !w_trap;

  wb_load_ext #(.XLEN(XLEN)) u_load_ext (
    .i_funct3 (w_funct3),
    .i_raw    (WB_MEM_RESULT),
    .o_data   (w_ld_data)
  );

  // Trap priority: load misalign, store misalign, then ECALL.
  always_comb begin
    w_trap  = 1'b0;
    w_cause = 4'd0;
    if (w_consume) begin
      if (w_opcode == OP_LOAD && MEM_LAM) begin
        w_trap  = 1'b1;
        w_cause = CAUSE_LOAD_MISALIGNED;
      end else if (w_opcode == OP_STORE && MEM_SAM) begin
        w_trap  = 1'b1;
        w_cause = CAUSE_STORE_MISALIGNED;
      end else if (WB_ECALL) begin
        w_trap  = 1'b1;
        w_cause = CAUSE_ECALL_M;
      end
    end
  end

  always_comb begin
    w_writes = 1'b0;
    w_wdata  = '0;
    case (w_opcode)
      OP_LOAD: begin
        w_writes = 1'b1;
        w_wdata  = w_ld_data;
      end
      OP_JAL, OP_JALR: begin
        w_writes = 1'b1;
        w_wdata  = WB_NPC;
      end
      OP_SYSTEM: begin
        w_writes = (w_funct3 != 3'b000);
        w_wdata  = WB_CSRFD;
      end
      OP_OP, OP_OPIMM, OP_OP32, OP_OPIMM32, OP_LUI, OP_AUIPC: begin
        w_writes = 1'b1;
        w_wdata  = WB_ALU_RESULT;
      end
      default: begin
        w_writes = 1'b0;
        w_wdata  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_trap) w_state_next = SAVE;
      SAVE:    w_state_next = VECTOR;
      VECTOR:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rf_we    <= 1'b0;
      r_rf_dr    <= '0;
      r_rf_data  <= '0;
      r_redirect <= 1'b0;
      r_br_flush <= 1'b0;
      r_target   <= '0;
      r_trap_v   <= 1'b0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_instret  <= '0;
    end else begin
      r_rf_we    <= w_retire && w_writes && (w_rd != 5'd0);
      r_rf_dr    <= w_rd;
      r_rf_data  <= w_wdata;
      r_br_flush <= w_retire && WB_PC_MUX;
      // SAVE is followed by VECTOR, so the vector redirect is armed from SAVE.
      r_redirect <= (r_state == SAVE) || (w_retire && WB_PC_MUX);
      r_target   <= (r_state == SAVE) ? MTVEC_ADDR : WB_ALU_RESULT;
      r_trap_v   <= w_trap;
      if (w_trap) begin
        r_mepc   <= WB_NPC - XLEN'(4);
        r_mcause <= XLEN'(w_cause);
      end
      if (w_retire) r_instret <= r_instret + 64'd1;
    end
  end

  assign WB_STALL    = (r_state != IDLE);
  assign FLUSH       = (r_state != IDLE) || r_br_flush;
  assign RF_WE       = r_rf_we;
  assign RF_DR       = r_rf_dr;
  assign RF_DATA     = r_rf_data;
  assign PC_REDIRECT = r_redirect;
  assign PC_TARGET   = r_target;
  assign TRAP_V      = r_trap_v;
  assign MEPC        = r_mepc;
  assign MCAUSE      = r_mcause;
  assign INSTRET     = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage against a cycle-level behavioural model.
`default_nettype none

module tb_writeback_stage;

  localparam logic [63:0] C_MTVEC = 64'h100;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        WB_V = 1'b0;
  logic [31:0] WB_IR = '0;
  logic [63:0] WB_NPC = '0, WB_ALU_RESULT = '0, WB_MEM_RESULT = '0, WB_CSRFD = '0;
  logic        WB_PC_MUX = 1'b0, WB_ECALL = 1'b0, MEM_LAM = 1'b0, MEM_SAM = 1'b0;
  logic        WB_STALL, FLUSH, RF_WE, PC_REDIRECT, TRAP_V;
  logic [4:0]  RF_DR;
  logic [63:0] RF_DATA, PC_TARGET, MEPC, MCAUSE, INSTRET;

  writeback_stage dut (
    .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_IR(WB_IR), .WB_NPC(WB_NPC),
    .WB_ALU_RESULT(WB_ALU_RESULT), .WB_MEM_RESULT(WB_MEM_RESULT), .WB_CSRFD(WB_CSRFD),
    .WB_PC_MUX(WB_PC_MUX), .WB_ECALL(WB_ECALL), .MEM_LAM(MEM_LAM), .MEM_SAM(MEM_SAM),
    .WB_STALL(WB_STALL), .FLUSH(FLUSH), .RF_WE(RF_WE), .RF_DR(RF_DR), .RF_DATA(RF_DATA),
    .PC_REDIRECT(PC_REDIRECT), .PC_TARGET(PC_TARGET), .TRAP_V(TRAP_V),
    .MEPC(MEPC), .MCAUSE(MCAUSE), .INSTRET(INSTRET)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: m_busy counts cycles left in the trap sequence after an edge.
  int          m_busy;
  logic        m_we, m_redir, m_brflush, m_trapv;
  logic [4:0]  m_dr;
  logic [63:0] m_data, m_tgt, m_mepc, m_mcause, m_instret;

  function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0, f3, rd, op};
  endfunction

  function automatic logic [63:0] ext_load(input logic [2:0] f3, input logic [63:0] raw);
    case (f3)
      3'd0: return 64'($signed(raw[7:0]));
      3'd1: return 64'($signed(raw[15:0]));
      3'd2: return 64'($signed(raw[31:0]));
      3'd4: return raw & 64'hFF;
      3'd5: return raw & 64'hFFFF;
      3'd6: return raw & 64'hFFFF_FFFF;
      default: return raw;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_we = 0; m_redir = 0; m_brflush = 0; m_trapv = 0;
    m_dr = 0; m_data = 0; m_tgt = 0; m_mepc = 0; m_mcause = 0; m_instret = 0;
  endtask

  task automatic model_edge();
    logic [6:0] op;
    logic [2:0] f3;
    logic       consume, trap, wr;
    logic [63:0] cause, val;
    op = WB_IR[6:0];
    f3 = WB_IR[14:12];
    consume = WB_V && (m_busy == 0);
    trap = 1'b0; cause = 0;
    if (consume) begin
      if (op == 7'b0000011 && MEM_LAM) begin trap = 1; cause = 4; end
      else if (op == 7'b0100011 && MEM_SAM) begin trap = 1; cause = 6; end
      else if (WB_ECALL) begin trap = 1; cause = 11; end
    end
    wr = 1'b0; val = 0;
    case (op)
      7'b0000011: begin wr = 1; val = ext_load(f3, WB_MEM_RESULT); end
      7'b1101111, 7'b1100111: begin wr = 1; val = WB_NPC; end
      7'b1110011: begin wr = (f3 != 0); val = WB_CSRFD; end
      7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011, 7'b0110111, 7'b0010111:
        begin wr = 1; val = WB_ALU_RESULT; end
      default: wr = 0;
    endcase
    m_trapv   = trap;
    m_brflush = consume && !trap && WB_PC_MUX;
    m_redir   = (m_busy == 2) || m_brflush;
    m_tgt     = (m_busy == 2) ? C_MTVEC : WB_ALU_RESULT;
    m_we      = consume && !trap && wr && (WB_IR[11:7] != 0);
    m_dr      = WB_IR[11:7];
    m_data    = val;
    if (trap) begin m_mepc = WB_NPC - 4; m_mcause = cause; end
    if (consume && !trap) m_instret = m_instret + 1;
    m_busy = trap ? 2 : (m_busy > 0 ? m_busy - 1 : 0);
  endtask

  task automatic check_all();
    chk("rf_we", 64'(RF_WE), 64'(m_we));
    if (m_we) begin
      chk("rf_dr", 64'(RF_DR), 64'(m_dr));
      chk("rf_data", RF_DATA, m_data);
    end
    chk("pc_redirect", 64'(PC_REDIRECT), 64'(m_redir));
    if (m_redir) chk("pc_target", PC_TARGET, m_tgt);
    chk("trap_v", 64'(TRAP_V), 64'(m_trapv));
    chk("mepc", MEPC, m_mepc);
    chk("mcause", MCAUSE, m_mcause);
    chk("instret", INSTRET, m_instret);
    chk("wb_stall", 64'(WB_STALL), 64'(m_busy > 0));
    chk("flush", 64'(FLUSH), 64'((m_busy > 0) || m_brflush));
  endtask

  task automatic step(input logic v, input logic [31:0] ir, input logic [63:0] npc,
                      input logic [63:0] alu, input logic [63:0] mem, input logic [63:0] csr,
                      input logic pcm, input logic ec, input logic lam, input logic sam);
    WB_V = v; WB_IR = ir; WB_NPC = npc; WB_ALU_RESULT = alu; WB_MEM_RESULT = mem;
    WB_CSRFD = csr; WB_PC_MUX = pcm; WB_ECALL = ec; MEM_LAM = lam; MEM_SAM = sam;
    model_edge();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rf_we"}, 64'(RF_WE), 0);
    chk({tag, "_redir"}, 64'(PC_REDIRECT), 0);
    chk({tag, "_trap_v"}, 64'(TRAP_V), 0);
    chk({tag, "_stall"}, 64'(WB_STALL), 0);
    chk({tag, "_flush"}, 64'(FLUSH), 0);
    chk({tag, "_mepc"}, MEPC, 0);
    chk({tag, "_mcause"}, MCAUSE, 0);
    chk({tag, "_instret"}, INSTRET, 0);
    chk({tag, "_rf_data"}, RF_DATA, 0);
    chk({tag, "_target"}, PC_TARGET, 0);
  endtask

  localparam logic [6:0] C_OPS [13] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
    7'b0111011, 7'b0011011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
    7'b1100011, 7'b1110011, 7'b0001111};

  initial begin
    logic [31:0] ld_ir;
    model_reset();
    #2;
    check_zero("reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #4;

    // LB / LBU of 0x80 into x5.
    ld_ir = mk_ir(7'b0000011, 3'd0, 5'd5);
    step(1, ld_ir, 64'h1004, 0, 64'h80, 0, 0, 0, 0, 0);
    chk("lb_value", RF_DATA, 64'hFFFF_FFFF_FFFF_FF80);
    step(1, mk_ir(7'b0000011, 3'd4, 5'd5), 64'h1008, 0, 64'h80, 0, 0, 0, 0, 0);
    chk("lbu_value", RF_DATA, 64'h80);
    // ADDI x0 is retired but not written.
    step(1, mk_ir(7'b0010011, 3'd0, 5'd0), 64'h100C, 7, 0, 0, 0, 0, 0, 0);
    chk("addi_x0_instret", INSTRET, 64'd3);
    // Taken BEQ.
    step(1, mk_ir(7'b1100011, 3'd0, 5'd0), 64'h1010, 64'h2000, 0, 0, 1, 0, 0, 0);
    chk("beq_target", PC_TARGET, 64'h2000);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // ECALL: SAVE then VECTOR; an input offered during SAVE is dropped.
    step(1, mk_ir(7'b1110011, 3'd0, 5'd0), 64'h1004, 0, 0, 0, 0, 1, 0, 0);
    chk("ecall_mepc", MEPC, 64'h1000);
    chk("ecall_mcause", MCAUSE, 64'd11);
    step(1, mk_ir(7'b0010011, 3'd0, 5'd9), 64'h2004, 64'h55, 0, 0, 0, 0, 0, 0);
    chk("vector_target", PC_TARGET, 64'h100);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Misaligned LD into x3, with a branch flag that the trap overrides.
    step(1, mk_ir(7'b0000011, 3'd3, 5'd3), 64'h3008, 64'h4000, 64'h1234, 0, 1, 0, 1, 0);
    chk("lam_mcause", MCAUSE, 64'd4);
    step(1, mk_ir(7'b0010011, 3'd0, 5'd7), 64'h300C, 64'h9, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      logic [4:0] rd;
      op = C_OPS[$urandom_range(0, 12)];
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      step($urandom_range(0, 3) != 0,
           {17'($urandom), 3'($urandom), rd, op},
           {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end

    // Reset asserted during SAVE abandons the trap immediately.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, mk_ir(7'b1110011, 3'd0, 5'd0), 64'h5004, 0, 0, 0, 0, 1, 0, 0);
    #2;
    RESET = 1'b0;
    #1;
    check_zero("mid_trap_reset");
    model_reset();
    WB_V = 1'b0; WB_ECALL = 1'b0;
    @(posedge CLK);
    #1;
    chk("held_reset_trap_v", 64'(TRAP_V), 0);
    @(negedge CLK);
    RESET = 1'b1;
    #4;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, mk_ir(7'b0010011, 3'd0, 5'd1), 64'h6004, 64'h42, 0, 0, 0, 0, 0, 0);
    chk("post_reset_instret", INSTRET, 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
